// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and byte-lane helpers for the direct-mapped data cache.
package cache_pkg;

    localparam int unsigned TAG_W    = 3;
    localparam int unsigned INDEX_W  = 3;
    localparam int unsigned OFFSET_W = 2;
    localparam int unsigned NUM_SETS = 8;
    localparam int unsigned BLOCK_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BACK,
        MEM_READ_ST,
        UPDATE
    } state_t;

    function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0]  block,
                                            input logic [OFFSET_W-1:0] offset);
        return block[{offset, 3'b000} +: 8];
    endfunction

    function automatic logic [BLOCK_W-1:0] merge_byte(input logic [BLOCK_W-1:0]  block,
                                                      input logic [OFFSET_W-1:0] offset,
                                                      input logic [7:0]          data);
        logic [BLOCK_W-1:0] b;
        b = block;
        b[{offset, 3'b000} +: 8] = data;
        return b;
    endfunction

endpackage

// File: rtl/cache_array.sv
// Cache storage: per-set data, tag, valid and dirty, with a CPU byte-write port,
// a block-fill port and a combinational read of the indexed set.
module cache_array
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  index,
    input  logic                byte_we,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [7:0]          wdata,
    input  logic                fill_en,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_data,
    output logic [BLOCK_W-1:0]  block,
    output logic [TAG_W-1:0]    tag,
    output logic                valid,
    output logic                dirty
);

    logic [BLOCK_W-1:0] data_q  [NUM_SETS];
    logic [TAG_W-1:0]   tag_q   [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;

    // Data and tags are not reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[index] <= fill_data;
            tag_q[index]  <= fill_tag;
        end else if (byte_we) begin
            data_q[index] <= merge_byte(data_q[index], offset, wdata);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (byte_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    always_comb begin
        block = data_q[index];
        tag   = tag_q[index];
        valid = valid_q[index];
        dirty = dirty_q[index];
    end

endmodule

// File: rtl/cache.sv
// Direct-mapped write-back, write-allocate byte cache in front of a 32-bit block memory.
// Define CACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module cache
    import cache_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    output logic        BUSYWAIT,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    input  logic [7:0]  ADDRESS,
    input  logic        MEM_BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    output logic [5:0]  MEM_ADDRESS
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);

    state_t               state;
    logic [5:0]           miss_addr_q;
    logic [7:0]           readdata_q;
    logic [INDEX_W-1:0]   index;
    logic [BLOCK_W-1:0]   block;
    logic [TAG_W-1:0]     tag;
    logic                 valid, dirty, hit, idle_hit, req, rd;

    assign req = READ | WRITE;
    assign rd  = READ & ~WRITE;

    // Once a miss is taken the latched block address drives the array, so a CPU
    // dropping its strobes mid-miss cannot redirect the refill.
    assign index    = (state == IDLE) ? ADDRESS[4:2] : miss_addr_q[2:0];
    assign hit      = valid && (tag == ADDRESS[7:5]);
    assign idle_hit = (state == IDLE) && hit;
    assign BUSYWAIT = req && !idle_hit;

    always_comb begin
        READDATA = readdata_q;
        if (idle_hit && rd) READDATA = get_byte(block, ADDRESS[1:0]);
    end

    cache_array u_array (
        .clk       (CLK),
        .reset     (RESET),
        .index     (index),
        .byte_we   (idle_hit && WRITE),
        .offset    (ADDRESS[1:0]),
        .wdata     (WRITEDATA),
        .fill_en   (state == UPDATE),
        .fill_tag  (miss_addr_q[5:3]),
        .fill_data (MEM_READDATA),
        .block     (block),
        .tag       (tag),
        .valid     (valid),
        .dirty     (dirty)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            readdata_q    <= '0;
            miss_addr_q   <= '0;
        end else begin
            if (idle_hit && rd) readdata_q <= get_byte(block, ADDRESS[1:0]);
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        miss_addr_q <= ADDRESS[7:2];
                        if (dirty) begin
                            state         <= WRITE_BACK;
                            MEM_WRITE     <= 1'b1;
                            MEM_ADDRESS   <= {tag, ADDRESS[4:2]};
                            MEM_WRITEDATA <= block;
                        end else begin
                            state       <= MEM_READ_ST;
                            MEM_READ    <= 1'b1;
                            MEM_ADDRESS <= ADDRESS[7:2];
                        end
                    end
                end
                WRITE_BACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state       <= MEM_READ_ST;
                        MEM_WRITE   <= 1'b0;
                        MEM_READ    <= 1'b1;
                        MEM_ADDRESS <= miss_addr_q;
                    end
                end
                MEM_READ_ST: begin
                    if (!MEM_BUSYWAIT) begin
                        state    <= UPDATE;
                        MEM_READ <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count_q, miss_count_q;
    logic        refill_done_q;

    // The hit that completes a refilled access was already counted as a miss.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_count_q   <= '0;
            miss_count_q  <= '0;
            refill_done_q <= 1'b0;
        end else begin
            if (state == UPDATE)    refill_done_q <= 1'b1;
            else if (state == IDLE) refill_done_q <= 1'b0;
            if (state == IDLE && req) begin
                if (hit && !refill_done_q && hit_count_q != 16'hFFFF)
                    hit_count_q <= hit_count_q + 16'd1;
                if (!hit && miss_count_q != 16'hFFFF)
                    miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end

    assign HIT_COUNT  = hit_count_q;
    assign MISS_COUNT = miss_count_q;
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_cache.sv
// Directed self-checking bench for the cache, with a small block memory model
// that answers each request after a fixed number of busy cycles.
module tb_cache;

    logic        CLK = 1'b0;
    logic        RESET, BUSYWAIT, READ, WRITE;
    logic [7:0]  WRITEDATA, READDATA, ADDRESS;
    logic        MEM_BUSYWAIT, MEM_READ, MEM_WRITE;
    logic [31:0] MEM_WRITEDATA, MEM_READDATA;
    logic [5:0]  MEM_ADDRESS;
`ifdef CACHE_STATS_EN
    logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

    always #5 CLK = ~CLK;

    cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BUSYWAIT      (BUSYWAIT),
        .READ          (READ),
        .WRITE         (WRITE),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .ADDRESS       (ADDRESS),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_ADDRESS   (MEM_ADDRESS)
`ifdef CACHE_STATS_EN
        ,
        .HIT_COUNT     (HIT_COUNT),
        .MISS_COUNT    (MISS_COUNT)
`endif
    );

    // Memory model: busy for 3 cycles of a request, completes on the 4th edge.
    logic [31:0] mem [64];
    int          mem_cnt;

    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt != 3);

    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE0000 | i;
            mem[1]       <= 32'h44332211;
            mem[9]       <= 32'h88776655;
            mem[16]      <= 32'hDDCCBBAA;
            mem_cnt      <= 0;
            MEM_READDATA <= '0;
        end else if (MEM_READ | MEM_WRITE) begin
            if (mem_cnt == 3) begin
                mem_cnt <= 0;
                if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
                else           MEM_READDATA <= mem[MEM_ADDRESS];
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          stalls;
    logic        saw_rd, saw_wr;
    logic [5:0]  rd_addr, wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  first_rdata, rdata;

    task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        READ = r; WRITE = w; ADDRESS = a; WRITEDATA = d;
        #1;
        first_rdata = READDATA;
        stalls = 0; saw_rd = 1'b0; saw_wr = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        while (BUSYWAIT && stalls < 60) begin
            @(posedge CLK); #1;
            stalls++;
            if (MEM_READ)  begin saw_rd = 1'b1; rd_addr = MEM_ADDRESS; end
            if (MEM_WRITE) begin saw_wr = 1'b1; wr_addr = MEM_ADDRESS; wr_data = MEM_WRITEDATA; end
            if (MEM_READ && MEM_WRITE) check("both_strobes", 1, 0);
        end
        if (BUSYWAIT) check("busywait_timeout", 1, 0);
        rdata = READDATA;
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busywait", BUSYWAIT, 0);
        check("rst_mem_read", MEM_READ, 0);
        check("rst_mem_write", MEM_WRITE, 0);
        check("rst_mem_addr", MEM_ADDRESS, 0);
        check("rst_mem_wdata", MEM_WRITEDATA, 0);
        check("rst_readdata", READDATA, 0);
        @(negedge CLK); RESET = 1'b0;

        // Clean read miss on block 1.
        access(1, 0, 8'h05, 8'h00);
        check("miss1_stall_start", stalls > 0, 1);
        check("miss1_saw_read", saw_rd, 1);
        check("miss1_rd_addr", rd_addr, 6'h01);
        check("miss1_no_write", saw_wr, 0);
        check("miss1_stalls", stalls, 6);
        check("miss1_data", rdata, 8'h22);

        // Read hit: no stall, data in the same cycle.
        access(1, 0, 8'h04, 8'h00);
        check("hit_stalls", stalls, 0);
        check("hit_first_data", first_rdata, 8'h11);
        check("hit_no_mem", saw_rd | saw_wr, 0);

        // Write hit then read it back.
        access(0, 1, 8'h07, 8'hAA);
        check("whit_stalls", stalls, 0);
        check("whit_no_mem", saw_rd | saw_wr, 0);
        access(1, 0, 8'h07, 8'h00);
        check("whit_readback", first_rdata, 8'hAA);

        // Conflict miss on dirty set 1: write-back then refill from block 9.
        access(1, 0, 8'h25, 8'h00);
        check("evict_hold_data", first_rdata, 8'hAA);
        check("evict_saw_wb", saw_wr, 1);
        check("evict_wb_addr", wr_addr, 6'h01);
        check("evict_wb_data", wr_data, 32'hAA332211);
        check("evict_rd_addr", rd_addr, 6'h09);
        check("evict_stalls", stalls, 10);
        check("evict_data", rdata, 8'h66);
        check("evict_mem1", mem[1], 32'hAA332211);

        // Write miss on clean, invalid set 0, then evict it.
        access(0, 1, 8'h40, 8'h5C);
        check("wmiss_rd_addr", rd_addr, 6'h10);
        check("wmiss_no_wb", saw_wr, 0);
        check("wmiss_stalls", stalls, 6);
        access(1, 0, 8'h02, 8'h00);
        check("wmiss_wb_addr", wr_addr, 6'h10);
        check("wmiss_wb_data", wr_data, 32'hDDCCBB5C);
        check("wmiss_rd_addr2", rd_addr, 6'h00);
        check("wmiss_data", rdata, 8'hDE);

        // Reset in the middle of a refill.
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h05;
        repeat (2) @(posedge CLK);
        #1;
        check("mid_mem_read", MEM_READ, 1);
        @(negedge CLK);
        RESET = 1'b1; READ = 1'b0;
        @(posedge CLK); #1;
        check("mid_rst_mem_read", MEM_READ, 0);
        check("mid_rst_busywait", BUSYWAIT, 0);
        check("mid_rst_mem_addr", MEM_ADDRESS, 0);
        @(negedge CLK); RESET = 1'b0;
        access(1, 0, 8'h05, 8'h00);
        check("post_rst_miss", saw_rd, 1);
        check("post_rst_stalls", stalls, 6);
        check("post_rst_data", rdata, 8'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
